// File: rtl/ps2_mouse_init_if.sv
// ps2_mouse_init_if
// Groups the signals exchanged between the mouse configuration sequencer,
// the PS/2 byte transceiver and the downstream packet decoder.
//   Transceiver -> sequencer : istrobe, ibyte, oack, timeout
//   Sequencer -> transceiver : oreq, obyte
//   Sequencer -> decoder     : rx_strobe, rx_byte
//   Sequencer status         : ready, error, retries
// Modport master is the sequencer's view; modport slave is the environment's.
interface ps2_mouse_init_if;
    logic       istrobe;
    logic [7:0] ibyte;
    logic       oack;
    logic       timeout;
    logic       oreq;
    logic [7:0] obyte;
    logic       rx_strobe;
    logic [7:0] rx_byte;
    logic       ready;
    logic       error;
    logic [2:0] retries;

    modport master (
        input  istrobe, ibyte, oack, timeout,
        output oreq, obyte, rx_strobe, rx_byte, ready, error, retries
    );

    modport slave (
        output istrobe, ibyte, oack, timeout,
        input  oreq, obyte, rx_strobe, rx_byte, ready, error, retries
    );
endinterface

// File: rtl/ps2_mouse_init.sv
// ps2_mouse_init
// PS/2 mouse configuration sequencer. After reset or a restart pulse it walks
// a fixed script (reset, BAT/ID, sample rate, resolution, enable reporting),
// checks every response, retries on failure and finally forwards received
// bytes to the packet decoder.
// Ports:
//   sysclk  - system clock
//   reset_n - asynchronous active-low reset
//   clk_en  - clock enable; all state advances only when high
//   restart - single-cycle pulse, restarts the script and clears retries/error
//   bus     - ps2_mouse_init_if.master: transceiver handshake, forwarded
//             bytes and status (ready, error, retries)
module ps2_mouse_init #(
    parameter logic [7:0]  SAMPLE_RATE = 8'd100,
    parameter logic [7:0]  RESOLUTION  = 8'd2,
    parameter logic [19:0] TO_CYCLES   = 20'd1000000,
    parameter logic [2:0]  MAX_RETRY   = 3'd3
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic              restart,
    ps2_mouse_init_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'd13;
    localparam logic [7:0] RESEND    = 8'hFE;

    // Script ROM: entry kind (1 = send, 0 = expect).
    function automatic logic rom_is_send(input logic [3:0] idx);
        logic r;
        case (idx)
            4'd0, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    // Script ROM: byte to send or byte expected.
    function automatic logic [7:0] rom_byte(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'hFF;
            4'd1:    r = 8'hFA;
            4'd2:    r = 8'hAA;
            4'd3:    r = 8'h00;
            4'd4:    r = 8'hF3;
            4'd5:    r = 8'hFA;
            4'd6:    r = SAMPLE_RATE;
            4'd7:    r = 8'hFA;
            4'd8:    r = 8'hE8;
            4'd9:    r = 8'hFA;
            4'd10:   r = RESOLUTION;
            4'd11:   r = 8'hFA;
            4'd12:   r = 8'hF4;
            4'd13:   r = 8'hFA;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_t      state_r, state_pre_s, state_next_s;
    logic [3:0]  step_r, step_pre_s, step_next_s, step_inc_s;
    logic [3:0]  last_send_r, last_send_next_s;
    logic [2:0]  retries_r, retries_pre_s, retries_next_s, retry_inc_s;
    logic [19:0] to_cnt_r, to_cnt_next_s;
    logic        to_clr_s, to_expired_s, fail_s, in_wait_s;
    logic        oreq_r;
    logic [7:0]  obyte_r;
    logic        rx_strobe_r, rx_strobe_next_s;
    logic [7:0]  rx_byte_r, rx_byte_next_s;
    logic        ready_r, error_r;

    assign step_inc_s   = step_r + 4'd1;
    assign retry_inc_s  = retries_r + 3'd1;
    assign to_expired_s = (to_cnt_r >= TO_CYCLES);
    assign in_wait_s    = (state_r == ST_WAIT_ACK) || (state_r == ST_WAIT_RESP);

    // Event decode: next state/step before the generic failure handling.
    always_comb begin
        state_pre_s      = state_r;
        step_pre_s       = step_r;
        last_send_next_s = last_send_r;
        retries_pre_s    = retries_r;
        to_clr_s         = 1'b0;
        fail_s           = 1'b0;
        rx_strobe_next_s = 1'b0;
        rx_byte_next_s   = rx_byte_r;
        if (restart) begin
            // Restart outranks everything, including a coincident byte.
            state_pre_s   = ST_IDLE;
            step_pre_s    = 4'd0;
            retries_pre_s = 3'd0;
            to_clr_s      = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_pre_s = ST_SEND;
                    step_pre_s  = 4'd0;
                    to_clr_s    = 1'b1;
                end
                ST_SEND: begin
                    last_send_next_s = step_r;
                    state_pre_s      = ST_WAIT_ACK;
                    to_clr_s         = 1'b1;
                end
                ST_WAIT_ACK: begin
                    // Received bytes are ignored until the transmit completes.
                    if (bus.oack) begin
                        step_pre_s  = step_inc_s;
                        state_pre_s = ST_WAIT_RESP;
                        to_clr_s    = 1'b1;
                    end else if (bus.timeout || to_expired_s) begin
                        fail_s = 1'b1;
                    end else begin
                        fail_s = 1'b0;
                    end
                end
                ST_WAIT_RESP: begin
                    if (bus.istrobe) begin
                        if (bus.ibyte == rom_byte(step_r)) begin
                            to_clr_s = 1'b1;
                            if (step_r == LAST_STEP) begin
                                state_pre_s = ST_RUN;
                            end else if (rom_is_send(step_inc_s)) begin
                                step_pre_s  = step_inc_s;
                                state_pre_s = ST_SEND;
                            end else begin
                                step_pre_s  = step_inc_s;
                            end
                        end else if (bus.ibyte == RESEND) begin
                            // Device asked for the last command again.
                            retries_pre_s = retry_inc_s;
                            if (retry_inc_s == MAX_RETRY) begin
                                state_pre_s = ST_FAIL;
                            end else begin
                                step_pre_s  = last_send_r;
                                state_pre_s = ST_SEND;
                            end
                        end else begin
                            fail_s = 1'b1;
                        end
                    end else if (bus.timeout || to_expired_s) begin
                        fail_s = 1'b1;
                    end else begin
                        fail_s = 1'b0;
                    end
                end
                ST_RUN: begin
                    // Line timeouts are ignored here: an idle mouse is legal.
                    if (bus.istrobe) begin
                        rx_strobe_next_s = 1'b1;
                        rx_byte_next_s   = bus.ibyte;
                    end else begin
                        rx_strobe_next_s = 1'b0;
                    end
                end
                ST_FAIL: begin
                    state_pre_s = ST_FAIL;
                end
                default: begin
                    state_pre_s = ST_IDLE;
                    step_pre_s  = 4'd0;
                end
            endcase
        end
    end

    // Failure resolution: count the failure, then retry from step 0 or give up.
    always_comb begin
        if (fail_s) begin
            retries_next_s = retry_inc_s;
            if (retry_inc_s == MAX_RETRY) begin
                state_next_s = ST_FAIL;
                step_next_s  = step_pre_s;
            end else begin
                state_next_s = ST_SEND;
                step_next_s  = 4'd0;
            end
        end else begin
            retries_next_s = retries_pre_s;
            state_next_s   = state_pre_s;
            step_next_s    = step_pre_s;
        end
    end

    // Response timer: runs only while waiting, clears on entry/accepted byte, saturates.
    always_comb begin
        if (to_clr_s || fail_s || !in_wait_s) begin
            to_cnt_next_s = 20'd0;
        end else if (to_cnt_r == 20'hFFFFF) begin
            to_cnt_next_s = to_cnt_r;
        end else begin
            to_cnt_next_s = to_cnt_r + 20'd1;
        end
    end

    // State and registered outputs; everything holds while clk_en is low.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            step_r      <= 4'd0;
            last_send_r <= 4'd0;
            retries_r   <= 3'd0;
            to_cnt_r    <= 20'd0;
            oreq_r      <= 1'b0;
            obyte_r     <= 8'h00;
            rx_strobe_r <= 1'b0;
            rx_byte_r   <= 8'h00;
            ready_r     <= 1'b0;
            error_r     <= 1'b0;
        end else if (clk_en) begin
            state_r     <= state_next_s;
            step_r      <= step_next_s;
            last_send_r <= last_send_next_s;
            retries_r   <= retries_next_s;
            to_cnt_r    <= to_cnt_next_s;
            // oreq is high exactly for the SEND cycle.
            oreq_r      <= (state_next_s == ST_SEND);
            if (state_next_s == ST_SEND) begin
                obyte_r <= rom_byte(step_next_s);
            end
            rx_strobe_r <= rx_strobe_next_s;
            rx_byte_r   <= rx_byte_next_s;
            ready_r     <= (state_next_s == ST_RUN);
            error_r     <= (state_next_s == ST_FAIL);
        end
    end

    assign bus.oreq      = oreq_r;
    assign bus.obyte     = obyte_r;
    assign bus.rx_strobe = rx_strobe_r;
    assign bus.rx_byte   = rx_byte_r;
    assign bus.ready     = ready_r;
    assign bus.error     = error_r;
    assign bus.retries   = retries_r;

endmodule

// File: tb/tb_ps2_mouse_init.sv
// tb_ps2_mouse_init
// Directed bench for ps2_mouse_init: acts as the transceiver (acks transmit
// requests, injects response bytes and timeouts) and compares every output
// against hand-computed values.
module tb_ps2_mouse_init;

    logic sysclk;
    logic reset_n;
    logic clk_en;
    logic restart;
    int   checks;
    int   errors;
    int   tx_count;
    int   stray;

    ps2_mouse_init_if bus ();

    ps2_mouse_init #(
        .SAMPLE_RATE (8'd100),
        .RESOLUTION  (8'd2),
        .TO_CYCLES   (20'd50),
        .MAX_RETRY   (3'd3)
    ) dut (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .restart (restart),
        .bus     (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Hard stop in case something upstream hangs.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a transmit request, check its byte and one-cycle width, then ack it.
    task automatic expect_tx(input string tag, input logic [7:0] exp_byte, input int budget);
        int n;
        n = 0;
        while (bus.oreq !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_oreq"}, {7'd0, bus.oreq}, 8'd1);
        check({tag, "_obyte"}, bus.obyte, exp_byte);
        tx_count++;
        tick();
        check({tag, "_oreq_pulse"}, {7'd0, bus.oreq}, 8'd0);
        bus.oack = 1'b1;
        tick();
        bus.oack = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.ibyte   = b;
        bus.istrobe = 1'b1;
        tick();
        bus.istrobe = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic script_head(input string tag, input int budget);
        expect_tx({tag, "_ff"}, 8'hFF, budget);
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h00);
    endtask

    task automatic script_tail(input string tag, input int budget);
        expect_tx({tag, "_f3"}, 8'hF3, budget);
        send_rx(8'hFA);
        expect_tx({tag, "_rate"}, 8'h64, 0);
        send_rx(8'hFA);
        expect_tx({tag, "_e8"}, 8'hE8, 0);
        send_rx(8'hFA);
        expect_tx({tag, "_res"}, 8'h02, 0);
        send_rx(8'hFA);
        expect_tx({tag, "_f4"}, 8'hF4, 0);
        check({tag, "_ready_before"}, {7'd0, bus.ready}, 8'd0);
        send_rx(8'hFA);
        check({tag, "_ready"}, {7'd0, bus.ready}, 8'd1);
        check({tag, "_error"}, {7'd0, bus.error}, 8'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        tx_count     = 0;
        reset_n      = 1'b0;
        clk_en       = 1'b1;
        restart      = 1'b0;
        bus.istrobe  = 1'b0;
        bus.ibyte    = 8'h00;
        bus.oack     = 1'b0;
        bus.timeout  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_oreq", {7'd0, bus.oreq}, 8'd0);
        check("rst_obyte", bus.obyte, 8'h00);
        check("rst_ready", {7'd0, bus.ready}, 8'd0);
        check("rst_error", {7'd0, bus.error}, 8'd0);
        check("rst_retries", {5'd0, bus.retries}, 8'd0);
        check("rst_rx_strobe", {7'd0, bus.rx_strobe}, 8'd0);

        // Nominal script: IDLE cycle, then oreq in the second cycle
        #4 reset_n = 1'b1;
        check("nom_idle_oreq", {7'd0, bus.oreq}, 8'd0);
        tick();
        script_head("nom", 0);
        script_tail("nom", 0);
        check("nom_tx_count", tx_count[7:0], 8'd6);
        check("nom_retries", {5'd0, bus.retries}, 8'd0);

        // RUN pass-through
        send_rx(8'h08);
        check("run_strobe0", {7'd0, bus.rx_strobe}, 8'd1);
        check("run_byte0", bus.rx_byte, 8'h08);
        tick();
        check("run_strobe0_end", {7'd0, bus.rx_strobe}, 8'd0);
        send_rx(8'h10);
        check("run_strobe1", {7'd0, bus.rx_strobe}, 8'd1);
        check("run_byte1", bus.rx_byte, 8'h10);
        send_rx(8'hF0);
        check("run_strobe2", {7'd0, bus.rx_strobe}, 8'd1);
        check("run_byte2", bus.rx_byte, 8'hF0);
        tick();
        check("run_strobe2_end", {7'd0, bus.rx_strobe}, 8'd0);
        check("run_oreq", {7'd0, bus.oreq}, 8'd0);
        bus.timeout = 1'b1;
        tick();
        bus.timeout = 1'b0;
        tick();
        check("run_to_ready", {7'd0, bus.ready}, 8'd1);
        check("run_to_error", {7'd0, bus.error}, 8'd0);
        check("run_to_oreq", {7'd0, bus.oreq}, 8'd0);

        // Bad ID byte: failure, retry from FF
        pulse_restart();
        check("rs_ready", {7'd0, bus.ready}, 8'd0);
        expect_tx("bad_ff", 8'hFF, 2);
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h03);
        check("bad_retries", {5'd0, bus.retries}, 8'd1);
        script_head("bad2", 0);
        script_tail("bad2", 0);
        check("bad_retries_end", {5'd0, bus.retries}, 8'd1);

        // Resend request on F3
        pulse_restart();
        check("rsd_retries_clr", {5'd0, bus.retries}, 8'd0);
        script_head("rsd", 2);
        expect_tx("rsd_f3a", 8'hF3, 0);
        send_rx(8'hFE);
        check("rsd_retries", {5'd0, bus.retries}, 8'd1);
        script_tail("rsd", 0);
        check("rsd_retries_end", {5'd0, bus.retries}, 8'd1);

        // Silent device: three FF attempts, then FAIL with no further oreq
        pulse_restart();
        tx_count = 0;
        for (int i = 0; i < 3; i++) begin
            expect_tx("sil_ff", 8'hFF, 100);
        end
        stray = 0;
        for (int i = 0; i < 1060; i++) begin
            tick();
            if (bus.oreq === 1'b1) stray++;
        end
        check("sil_tx_count", tx_count[7:0], 8'd3);
        check("sil_stray_oreq", stray[7:0], 8'd0);
        check("sil_error", {7'd0, bus.error}, 8'd1);
        check("sil_ready", {7'd0, bus.ready}, 8'd0);
        check("sil_retries", {5'd0, bus.retries}, 8'd3);
        pulse_restart();
        check("sil_rs_error", {7'd0, bus.error}, 8'd0);
        check("sil_rs_retries", {5'd0, bus.retries}, 8'd0);
        check("sil_rs_idle_oreq", {7'd0, bus.oreq}, 8'd0);
        tick();
        expect_tx("sil_rs_ff", 8'hFF, 0);

        // Asynchronous reset while F3 (step 4) is being requested
        pulse_restart();
        send_rx(8'hFE);
        pulse_restart();
        script_head("ar", 2);
        check("ar_oreq_f3", {7'd0, bus.oreq}, 8'd1);
        check("ar_obyte_f3", bus.obyte, 8'hF3);
        #2 reset_n = 1'b0;
        #1;
        check("ar_oreq", {7'd0, bus.oreq}, 8'd0);
        check("ar_obyte", bus.obyte, 8'h00);
        check("ar_ready", {7'd0, bus.ready}, 8'd0);
        check("ar_error", {7'd0, bus.error}, 8'd0);
        check("ar_retries", {5'd0, bus.retries}, 8'd0);
        check("ar_rx_byte", bus.rx_byte, 8'h00);
        #1 reset_n = 1'b1;
        check("ar_idle_oreq", {7'd0, bus.oreq}, 8'd0);
        tick();
        check("ar_first_oreq", {7'd0, bus.oreq}, 8'd1);
        check("ar_first_obyte", bus.obyte, 8'hFF);

        // clk_en low freezes the request
        clk_en = 1'b0;
        tick();
        tick();
        tick();
        check("cen_oreq_hold", {7'd0, bus.oreq}, 8'd1);
        check("cen_obyte_hold", bus.obyte, 8'hFF);
        clk_en = 1'b1;
        expect_tx("cen_ff", 8'hFF, 0);
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h00);
        script_tail("cen", 0);
        check("cen_retries", {5'd0, bus.retries}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_init.md
# ps2_mouse_init

PS/2 mouse configuration sequencer that sits between the low-level `ps2` byte transceiver and the mouse packet decoder. It owns the transceiver's transmit side. After reset, or on request, it runs a fixed command script: reset, read BAT/ID, set sample rate, set resolution, enable reporting. It checks every response, retries on failure, and then passes received bytes through to the packet decoder.

## Interface
Parameters:
- `SAMPLE_RATE`, 8'd100: argument sent with the 0xF3 command.
- `RESOLUTION`, 8'd2: argument sent with the 0xE8 command.
- `TO_CYCLES`, 20'd1000000: response timeout, counted in clk_en cycles.
- `MAX_RETRY`, 3'd3: number of failures before the block declares a fault.

Ports:
- `sysclk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `clk_en` in 1: clock enable; all state advances only when clk_en=1.
- `restart` in 1: single-cycle pulse; restarts the script from step 0 and clears the retry count and error.
- `istrobe` in 1: received-byte strobe from the transceiver.
- `ibyte` in 8: received byte.
- `oack` in 1: transmit-complete pulse from the transceiver.
- `timeout` in 1: line timeout from the transceiver.
- `oreq` out 1: transmit request, one clk_en cycle long.
- `obyte` out 8: byte to transmit; valid while oreq=1.
- `rx_strobe` out 1: forwarded-byte strobe; only in RUN.
- `rx_byte` out 8: forwarded byte.
- `ready` out 1: high while in RUN.
- `error` out 1: high while in FAIL.
- `retries` out 3: failure count for the current attempt.

## Operation
- Script ROM, indexed by `step` (4 bits). Each entry is Send (S) or Expect (E):
  0 S FF, 1 E FA, 2 E AA, 3 E 00, 4 S F3, 5 E FA, 6 S SAMPLE_RATE, 7 E FA, 8 S E8, 9 E FA, 10 S RESOLUTION, 11 E FA, 12 S F4, 13 E FA.
- States: IDLE, SEND, WAIT_ACK, WAIT_RESP, RUN, FAIL.
- IDLE: entered on reset or restart. Next cycle goes to SEND with step=0.
- SEND: drive oreq=1 with obyte=ROM byte for one cycle. Record `last_send`=step. Go to WAIT_ACK.
- WAIT_ACK:
  - oack → step+1, then WAIT_RESP.
  - timeout, or TO_CYCLES elapsed → failure.
  - istrobe is ignored.
- WAIT_RESP: on istrobe, compare ibyte with the ROM byte.
  - Match, and the next entry is S → SEND.
  - Match, and the next entry is E → stay in WAIT_RESP with step+1.
  - Match at step 13 → RUN.
  - ibyte=0xFE (resend) → retries+1; step=last_send; go to SEND. If retries reaches MAX_RETRY, go to FAIL instead.
  - Any other byte, timeout, or TO_CYCLES elapsed with no byte → failure.
- Failure: retries+1.
  - If the new value equals MAX_RETRY → FAIL and error=1.
  - Otherwise → step=0, SEND.
- The timeout counter clears on every entry to WAIT_ACK or WAIT_RESP and on every accepted byte. It counts clk_en cycles and saturates.
- RUN:
  - ready=1 and oreq=0.
  - Each istrobe produces rx_strobe=1 and rx_byte=ibyte, registered.
  - timeout is ignored; an idle mouse is legal.
- FAIL: holds with oreq=0. Exit only via restart or reset_n.
- restart has priority over every other event in the same cycle; a coincident istrobe byte is dropped.
- Coincident events:
  - In WAIT_RESP, istrobe wins over timeout.
  - In WAIT_ACK, oack wins over timeout.
- oreq is never reasserted before the matching oack or a failure.

## Timing
- Reset values:
  - state=IDLE, step=0.
  - oreq=0, obyte=8'h00.
  - rx_strobe=0, rx_byte=8'h00.
  - ready=0, error=0, retries=0.
- reset_n low at any point, including mid-transmit: all of the above take effect immediately (asynchronous). The script restarts from IDLE on release.
- oreq asserts 2 clk_en cycles after reset release or restart (IDLE, then SEND).
- A matching response followed by an S entry produces oreq 1 clk_en cycle after the istrobe cycle.
- rx_strobe/rx_byte appear 1 clk_en cycle after istrobe and are high for exactly 1 cycle.
- ready rises in the cycle after the final 0xFA istrobe.
- Failure detection: in the clk_en cycle after the timeout count reaches TO_CYCLES.
- With clk_en=0 all registers hold, including oreq, so pulses stretch in sysclk but not in clk_en cycles.

## Test plan
- Nominal script: BFM acks each oreq and answers FA/AA/00, then FA after each command → obyte sequence exactly FF, F3, 64, E8, 02, F4; 6 oreq pulses; ready=1 after the last FA; retries=0.
- Bad ID: answer 0x03 at step 3 → retries=1; next oreq carries FF; a nominal remainder reaches ready=1.
- Resend: answer 0xFE to F3 → next oreq carries F3 again; retries=1; completion is otherwise nominal.
- Silent device, TO_CYCLES=50, MAX_RETRY=3: BFM acks but never answers → 3 FF transmissions, then error=1, ready=0, and no further oreq for 1000 cycles. A restart pulse then produces oreq with FF and retries=0.
- RUN pass-through: after init, drive bytes 08, 10, F0 → three rx_strobe pulses, each 1 cycle after its istrobe, with rx_byte 08/10/F0; no oreq; an injected timeout causes no change.
- Async reset: assert reset_n=0 while oreq=1 at step 4 → all outputs reach reset values without a clock edge. After release, the first oreq carries FF.
